dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Data-cache controller for the MEM stage. It is the producer of the `CacheStall` signal that the MEM/WB, EX/MEM, ID/EX, IF/ID registers and the PC consume. The cache is direct-mapped, write-back and write-allocate. It serves one CPU load/store per cycle on a hit, and runs a writeback/refill handshake with data memory on a miss while holding the pipeline stalled.

## Interface
Parameters:
- `TAG_W`, 22: tag bits, `addr[31:10]`.
- `IDX_W`, 5: index bits, `addr[9:5]`, giving 32 lines.
- `LINE_W`, 256: line width in bits (32 bytes, 8 words).

Ports:
- `clk_i` in 1: clock. One clock only.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i` in 1: MEM stage has a load or store.
- `we_i` in 1: 1 = store, 0 = load.
- `addr_i` in 32: byte address, word-aligned.
- `wdata_i` in 32: store data.
- `rdata_o` out 32: load data.
- `stall_o` out 1: `CacheStall` to the pipeline registers.
- `mem_en_o` out 1: memory request.
- `mem_we_o` out 1: memory write.
- `mem_addr_o` out 32: line address, with `[4:0]` = 0.
- `mem_wdata_o` out 256: victim line.
- `mem_rdata_i` in 256: refill line.
- `mem_ack_i` in 1: memory done, 1-cycle pulse.

## Operation
- Lookup is combinational: `hit = req_i & valid[idx] & (tag[idx] == addr_i[31:10])`.
- Word select uses `addr_i[4:2]`.
- `stall_o = req_i & ~hit` in IDLE. It is 1 in every other state.
- Read hit: `rdata_o` = selected word in the same cycle. No state change.
- Write hit: at the posedge, the selected word is replaced with `wdata_i` and `dirty[idx]` is set to 1.
- No request: `rdata_o` = 0, `stall_o` = 0.
- FSM states are IDLE, WB, REFILL and DONE.
  - IDLE to WB: miss and `valid & dirty` on the victim line.
  - IDLE to REFILL: miss and the victim line is clean or invalid.
  - WB: `mem_en_o`=1, `mem_we_o`=1, `mem_addr_o`={victim tag, idx, 5'b0}, `mem_wdata_o`=victim line. On `mem_ack_i`, go to REFILL.
  - REFILL: `mem_en_o`=1, `mem_we_o`=0, `mem_addr_o`={`addr_i[31:5]`, 5'b0}. On `mem_ack_i`, write `mem_rdata_i` into the line, set tag, set valid=1, clear dirty, then go to DONE.
  - DONE: `stall_o`=1 and `mem_en_o`=0. Next state is IDLE, where the re-lookup hits and the access completes as a normal hit.
- `addr_i`, `we_i` and `wdata_i` are stable while `stall_o`=1, because the pipeline is frozen.
- `mem_en_o` stays asserted until the ack arrives. `mem_ack_i` outside WB/REFILL is ignored.
- Outputs when not driving a request: `mem_wdata_o`=0 and `mem_addr_o`=0.

## Timing
- Reset values:
  - State = IDLE.
  - All valid and dirty bits = 0.
  - `mem_en_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
  - `rdata_o`=0 and `stall_o`=0 while `req_i`=0.
  - Tag and data arrays are not reset.
- Hit latency is 0 cycles, with no stall.
- Clean miss stalls for N+2 cycles, where N is the cycles from `mem_en_o` rise to `mem_ack_i`. The count includes the IDLE miss cycle and DONE.
- Dirty miss stalls for Nw+Nr+2 cycles.
- Ack in the first cycle of WB/REFILL is legal, so N=1.
- Reset mid-WB or mid-REFILL:
  - The FSM goes to IDLE at the next edge and `mem_en_o` drops.
  - The partial transaction is abandoned and no line is updated.
- `rst_i` and `mem_ack_i` in the same cycle: reset wins.
- Store miss: allocation completes first. The write is then performed on the hit in the IDLE cycle after DONE, so the line ends up dirty.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_cnt_o` [31:0] and `miss_cnt_o` [31:0].
  - `hit_cnt_o` increments on each IDLE-cycle hit.
  - `miss_cnt_o` increments on each IDLE-to-WB/REFILL transition.
  - The post-DONE re-lookup is not counted as a hit.
  - Both counters wrap at 2^32 and are cleared by `rst_i`.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- `dcache_pkg` holds:
  - The state enum (IDLE/WB/REFILL/DONE).
  - The `TAG_W`, `IDX_W` and `LINE_W` constants.
  - The offset field position constants.
- Sub-module `dcache_sram`: a 32-entry array of {valid, dirty, tag, line} with one read port and one write port. Writes are synchronous and reads are combinational. Valid and dirty clear on `rst_i`.
- The FSM, hit logic and word merge live in `dcache_ctrl`.

## Test plan
- Cold load at 0x0000_0400, memory returns a line with word0 = 0xDEADBEEF and ack after 3 cycles:
  - `mem_we_o`=0 and `mem_addr_o`=0x400.
  - `stall_o` is high for 5 cycles.
  - `rdata_o`=0xDEADBEEF.
- Repeat the same load: `stall_o`=0 and `rdata_o`=0xDEADBEEF in the same cycle, with no `mem_en_o`.
- Store 0x12345678 to 0x404 (hit), then load 0x0000_0804 (same index, different tag):
  - WB to `mem_addr_o`=0x400, with `mem_wdata_o` word1 = 0x12345678.
  - Then REFILL from 0x800.
- Store miss to 0x1008: after refill, word2 = `wdata_i` and the dirty bit is set. A later conflict load to 0x2008 triggers WB.
- Assert `rst_i` for 1 cycle mid-REFILL:
  - `mem_en_o`=0 the next cycle.
  - A late `mem_ack_i` is ignored.
  - Re-issuing the load misses again.
- With `DCACHE_STATS_EN`, run the first three scenarios: `hit_cnt_o`=2 and `miss_cnt_o`=2.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int DC_TAG_W  = 22;
  localparam int DC_IDX_W  = 5;
  localparam int DC_LINE_W = 256;
  localparam int WORD_W    = 32;

  // Byte-address field positions: [31:10] tag, [9:5] index, [4:2] word offset.
  localparam int OFF_LSB = 2;
  localparam int OFF_W   = 3;
  localparam int IDX_LSB = 5;
  localparam int TAG_LSB = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_REFILL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Line storage: {valid, dirty, tag, line} x 2^IDX_W entries.
// Combinational read port, synchronous write port; only valid/dirty are reset.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int TAG_W  = DC_TAG_W,
  parameter int IDX_W  = DC_IDX_W,
  parameter int LINE_W = DC_LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              wr_dirty_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] line_q [LINES];

  // Any write installs a valid line; the caller decides whether it is dirty.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
      dirty_d[wr_idx_i] = wr_dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      line_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = line_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data-cache controller: hit logic, word merge and writeback/refill FSM.
// Optional DCACHE_STATS_EN adds hit_cnt_o / miss_cnt_o event counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int TAG_W  = DC_TAG_W,
  parameter int IDX_W  = DC_IDX_W,
  parameter int LINE_W = DC_LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
`endif
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  state_e state_q, state_d;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  woff;
  logic              rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line, merged;
  logic [31:0]       sel_word;
  logic              wr_en, wr_dirty;
  logic [LINE_W-1:0] wr_line;
  logic              unused_addr;

  assign tag         = addr_i[31 -: TAG_W];
  assign idx         = addr_i[IDX_LSB +: IDX_W];
  assign woff        = addr_i[OFF_LSB +: OFF_W];
  assign unused_addr = ^addr_i[OFF_LSB-1:0];

  dcache_sram #(.TAG_W(TAG_W), .IDX_W(IDX_W), .LINE_W(LINE_W)) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (wr_en & ~rst_i),
    .wr_idx_i   (idx),
    .wr_dirty_i (wr_dirty),
    .wr_tag_i   (tag),
    .wr_line_i  (wr_line)
  );

  assign hit      = req_i & rd_valid & (rd_tag == tag);
  assign sel_word = rd_line[woff*WORD_W +: WORD_W];

  always_comb begin
    merged = rd_line;
    merged[woff*WORD_W +: WORD_W] = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Address and store data are frozen by the stall, so refill and the post-DONE
  // re-lookup can keep reading them straight from the pipeline.
  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b1;
    rdata_o     = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    wr_en       = 1'b0;
    wr_dirty    = 1'b0;
    wr_line     = merged;
    case (state_q)
      ST_IDLE: begin
        stall_o = req_i & ~hit;
        if (hit) begin
          rdata_o = sel_word;
          if (we_i) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
          end
        end else if (req_i) begin
          state_d = (rd_valid & rd_dirty) ? ST_WB : ST_REFILL;
        end
      end
      ST_WB: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {rd_tag, idx, {IDX_LSB{1'b0}}};
        mem_wdata_o = rd_line;
        if (mem_ack_i) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        mem_en_o   = 1'b1;
        mem_addr_o = {addr_i[31:IDX_LSB], {IDX_LSB{1'b0}}};
        if (mem_ack_i) begin
          wr_en   = 1'b1;
          wr_line = mem_rdata_i;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        redo_q, redo_d;

  // The first IDLE cycle after DONE is the replay of a miss, not a fresh hit.
  always_comb begin
    redo_d     = (state_q == ST_DONE);
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_IDLE && hit && !redo_q) hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == ST_IDLE && state_d != ST_IDLE) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      redo_q     <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      redo_q     <= redo_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table of full accesses plus a reset-mid-refill sequence.
// Counter checks are compiled in when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_i = 1'b0;
  logic         we_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic [31:0]  wdata_i = '0;
  logic [31:0]  rdata_o;
  logic         stall_o;
  logic         mem_en_o, mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i = '0;
  logic         mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
`ifdef DCACHE_STATS_EN
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o),
`endif
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nw;
    int          nr;
    logic [31:0] base;
    int          exp_stalls;
    logic        exp_wb;
    logic [31:0] exp_wb_addr;
    int          wb_word;
    logic [31:0] exp_wb_val;
    logic [31:0] exp_rf_addr;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  int           r_stalls;
  logic         r_wb, r_first_en, r_idle_stall, r_idle_en;
  logic [31:0]  r_wb_addr, r_rf_addr, r_rdata, r_idle_rdata;
  logic [255:0] r_wb_line;

  // Refill pattern: word i = base ^ (i * 0x11111111).
  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base ^ (32'h1111_1111 * i);
    return l;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete access: acts as memory, acking WB after nw and REFILL after nr cycles.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input int nw, input int nr, input logic [31:0] base);
    int cyc;
    int k;
    cyc = 0;
    k = 0;
    r_stalls = 0;
    r_wb = 1'b0;
    r_wb_addr = '0;
    r_wb_line = '0;
    r_rf_addr = '0;
    @(negedge clk);
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d; mem_ack_i = 1'b0;
    mem_rdata_i = mk_line(base);
    #1;
    r_first_en = mem_en_o;
    while (stall_o === 1'b1 && cyc < 40) begin
      r_stalls++;
      if (mem_en_o === 1'b1 && mem_we_o === 1'b1) begin
        r_wb = 1'b1;
        r_wb_addr = mem_addr_o;
        r_wb_line = mem_wdata_o;
        k++;
        if (k >= nw) begin mem_ack_i = 1'b1; k = 0; end
      end else if (mem_en_o === 1'b1) begin
        r_rf_addr = mem_addr_o;
        k++;
        if (k >= nr) begin mem_ack_i = 1'b1; k = 0; end
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
      #1;
      cyc++;
    end
    checkOutput("access_timeout", 32'(cyc < 40), 32'd1);
    r_rdata = rdata_o;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0;
    #1;
    r_idle_stall = stall_o;
    r_idle_rdata = rdata_o;
    r_idle_en = mem_en_o;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h400,  32'h0,        0, 3, 32'hDEADBEEF, 5, 1'b0, 32'h0,    0, 32'h0,        32'h400,  1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'h400,  32'h0,        0, 1, 32'hDEADBEEF, 0, 1'b0, 32'h0,    0, 32'h0,        32'h0,    1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h404,  32'h12345678, 0, 1, 32'h0,        0, 1'b0, 32'h0,    0, 32'h0,        32'h0,    1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h804,  32'h0,        2, 1, 32'hB0B00000, 5, 1'b1, 32'h400,  1, 32'h12345678, 32'h800,  1'b1, 32'hA1A11111};
    vecs[4] = '{1'b1, 32'h1008, 32'hCAFEF00D, 0, 2, 32'hC0C00000, 4, 1'b0, 32'h0,    0, 32'h0,        32'h1000, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h2008, 32'h0,        1, 1, 32'hD0D00000, 4, 1'b1, 32'h1000, 2, 32'hCAFEF00D, 32'h2000, 1'b1, 32'hF2F22222};
    vecs[6] = '{1'b0, 32'h2008, 32'h0,        0, 1, 32'hD0D00000, 0, 1'b0, 32'h0,    0, 32'h0,        32'h0,    1'b1, 32'hF2F22222};
    vecs[7] = '{1'b0, 32'h20,   32'h0,        0, 1, 32'h0E0E0E0E, 3, 1'b0, 32'h0,    0, 32'h0,        32'h20,   1'b1, 32'h0E0E0E0E};
    vecs[8] = '{1'b0, 32'h3C,   32'h0,        0, 1, 32'h0E0E0E0E, 0, 1'b0, 32'h0,    0, 32'h0,        32'h0,    1'b1, 32'h79797979};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_stall",     32'(stall_o),  32'd0);
    checkOutput("rst_rdata",     rdata_o,       32'd0);
    checkOutput("rst_mem_en",    32'(mem_en_o), 32'd0);
    checkOutput("rst_mem_we",    32'(mem_we_o), 32'd0);
    checkOutput("rst_mem_addr",  mem_addr_o,    32'd0);
    checkOutput("rst_mem_wdata", 32'(|mem_wdata_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].nw, vecs[i].nr, vecs[i].base);
      checkOutput($sformatf("v%0d_stalls", i), 32'(r_stalls), 32'(vecs[i].exp_stalls));
      checkOutput($sformatf("v%0d_wb_seen", i), 32'(r_wb), 32'(vecs[i].exp_wb));
      if (vecs[i].exp_wb) begin
        checkOutput($sformatf("v%0d_wb_addr", i), r_wb_addr, vecs[i].exp_wb_addr);
        checkOutput($sformatf("v%0d_wb_word", i), r_wb_line[vecs[i].wb_word*32 +: 32], vecs[i].exp_wb_val);
      end
      if (vecs[i].exp_stalls > 0)
        checkOutput($sformatf("v%0d_rf_addr", i), r_rf_addr, vecs[i].exp_rf_addr);
      else
        checkOutput($sformatf("v%0d_hit_no_mem_en", i), 32'(r_first_en), 32'd0);
      if (vecs[i].chk_rd)
        checkOutput($sformatf("v%0d_rdata", i), r_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d_idle_stall", i), 32'(r_idle_stall), 32'd0);
      checkOutput($sformatf("v%0d_idle_rdata", i), r_idle_rdata, 32'd0);
      checkOutput($sformatf("v%0d_idle_mem_en", i), 32'(r_idle_en), 32'd0);
`ifdef DCACHE_STATS_EN
      if (i == 3) begin
        checkOutput("stats_hit_cnt",  hit_cnt_o,  32'd2);
        checkOutput("stats_miss_cnt", miss_cnt_o, 32'd2);
      end
`endif
    end

    // Reset lands in a REFILL cycle together with an ack; a later stray ack follows.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
    mem_rdata_i = mk_line(32'h55555555);
    #1;
    checkOutput("rstseq_miss_stall", 32'(stall_o), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("rstseq_refill_en",   32'(mem_en_o), 32'd1);
    checkOutput("rstseq_refill_addr", mem_addr_o,    32'h40);
    @(negedge clk);
    rst_i = 1'b1; mem_ack_i = 1'b1;
    #1;
    @(negedge clk);
    rst_i = 1'b0; req_i = 1'b0; mem_ack_i = 1'b1;
    #1;
    checkOutput("rstseq_en_drop", 32'(mem_en_o), 32'd0);
    checkOutput("rstseq_stall",   32'(stall_o),  32'd0);
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    checkOutput("rstseq_late_ack_en", 32'(mem_en_o), 32'd0);

    applyStimulus(1'b0, 32'h40, 32'h0, 0, 1, 32'h40404040);
    checkOutput("rstseq_reissue_stalls", 32'(r_stalls), 32'd3);
    checkOutput("rstseq_reissue_rf",     r_rf_addr,     32'h40);
    checkOutput("rstseq_reissue_rdata",  r_rdata,       32'h40404040);

    applyStimulus(1'b0, 32'h400, 32'h0, 0, 1, 32'h600DF00D);
    checkOutput("rstseq_old_line_gone", 32'(r_stalls), 32'd3);
    checkOutput("rstseq_old_line_rdata", r_rdata, 32'h600DF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
